// File: rtl/pwr_cntr_sched_pkg.sv
// Shared definitions for the power-counter read-modify-write scheduler:
// default geometry, FSM state encoding and a small width helper.
package pwr_cntr_pkg;

    localparam int NREQ_D = 4;   // number of requesters
    localparam int NDIR_D = 2;   // address MSB index (address is NDIR+1 bits)
    localparam int NCNT_D = 4;   // highest valid counter index
    localparam int DW_D   = 32;  // counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_CLR  = 2'd3
    } state_e;

    // Width of an index able to address n items (never less than one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwr_cntr_sched_if.sv
// Requester and counter-memory signals of the scheduler. The scheduler is
// the slave; the gate models and the memory together form the master side.
interface pwr_cntr_sched_if
    import pwr_cntr_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int NDIR = NDIR_D,
    parameter int DW   = DW_D
);
    logic [NREQ-1:0]          iReq;
    logic [NREQ*(NDIR+1)-1:0] iDir;
    logic                     iClr;
    logic [NREQ-1:0]          oBusy;
    logic [NREQ-1:0]          oAck;
    logic                     oDrop;
    logic                     oErr;
    logic [NDIR:0]            oDir;
    logic                     oLE;
    logic                     oDatoEn;
    logic [DW-1:0]            oDato;
    logic [DW-1:0]            iDato;

    modport master (
        output iReq, iDir, iClr, iDato,
        input  oBusy, oAck, oDrop, oErr, oDir, oLE, oDatoEn, oDato
    );

    modport slave (
        input  iReq, iDir, iClr, iDato,
        output oBusy, oAck, oDrop, oErr, oDir, oLE, oDatoEn, oDato
    );
endinterface

// File: rtl/pwr_cntr_sched_rr_arb.sv
// Combinational round-robin picker: searches the request vector starting
// one position after the pointer, wrapping around, and grants the first hit.
module rr_arb
    import pwr_cntr_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int IW   = idx_w(NREQ_D)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] j_s;
    logic          take_s;

    // Walk pointer+1 .. pointer+NREQ and keep only the first pending entry
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        j_s    = '0;
        take_s = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            j_s      = IW'((int'(ptr) + i) % NREQ);
            take_s   = req[j_s] & ~any;
            gnt[j_s] = gnt[j_s] | take_s;
            idx      = take_s ? j_s : idx;
            any      = any | take_s;
        end
    end

endmodule

// File: rtl/pwr_cntr_sched.sv
// Read-modify-write scheduler for the power-counter memory. Latches
// increment requests, serves them round-robin as a read cycle followed by a
// write of value+1, and runs a zeroing sweep over all counters on demand.
module pwr_cntr_sched
    import pwr_cntr_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int NDIR = NDIR_D,
    parameter int NCNT = NCNT_D,
    parameter int DW   = DW_D
) (
    input  logic              CLK,
    input  logic              RESET,
    pwr_cntr_sched_if.slave   bus
);

    localparam int AW = NDIR + 1;
    localparam int IW = idx_w(NREQ);
    localparam logic [AW-1:0]   DIR_LAST = AW'(NCNT);
    localparam logic [AW-1:0]   DIR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   DAT_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] REQ_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_r;
    logic [IW-1:0]   ptr_r;
    logic [NREQ-1:0] pend_r;
    logic [AW-1:0]   addr_r [NREQ];
    logic            clr_pend_r;
    logic [AW-1:0]   dir_r;
    logic            le_r;
    logic            daten_r;
    logic [DW-1:0]   dato_r;
    logic [NREQ-1:0] ack_r;
    logic            drop_r;
    logic            err_r;

    logic [NREQ-1:0] cap_s;
    logic [NREQ-1:0] bad_s;
    logic [NREQ-1:0] own_s;
    logic            drop_hit_s;
    logic            err_hit_s;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gidx_s;
    logic            any_s;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (pend_r),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (gidx_s),
        .any (any_s)
    );

    // Classify incoming requests: accept, drop as duplicate, or flag bad address
    always_comb begin
        cap_s      = '0;
        bad_s      = '0;
        drop_hit_s = 1'b0;
        err_hit_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            bad_s[k]   = bus.iDir[k*AW +: AW] > DIR_LAST;
            cap_s[k]   = bus.iReq[k] & ~pend_r[k] & ~bad_s[k];
            drop_hit_s = drop_hit_s | (bus.iReq[k] & pend_r[k]);
            err_hit_s  = err_hit_s | (bus.iReq[k] & bad_s[k]);
        end
        own_s = REQ_ONE << ptr_r;
    end

    // Scheduler FSM with request bookkeeping and registered memory-port outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            ptr_r      <= IW'(NREQ - 1);
            pend_r     <= '0;
            for (int k = 0; k < NREQ; k++) begin
                addr_r[k] <= '0;
            end
            clr_pend_r <= 1'b0;
            dir_r      <= '0;
            le_r       <= 1'b1;
            daten_r    <= 1'b0;
            dato_r     <= '0;
            ack_r      <= '0;
            drop_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            pend_r <= pend_r | cap_s;
            for (int k = 0; k < NREQ; k++) begin
                if (cap_s[k]) begin
                    addr_r[k] <= bus.iDir[k*AW +: AW];
                end
            end
            drop_r <= drop_r | drop_hit_s;
            err_r  <= err_r | err_hit_s;
            ack_r  <= '0;
            // A clear during an increment waits; a clear during a sweep is ignored
            if (bus.iClr && (state_r != ST_CLR)) begin
                clr_pend_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (clr_pend_r) begin
                        state_r <= ST_CLR;
                        dir_r   <= '0;
                        le_r    <= 1'b0;
                        daten_r <= 1'b1;
                        dato_r  <= '0;
                    end else if (any_s) begin
                        state_r <= ST_RD;
                        dir_r   <= addr_r[gidx_s];
                        ptr_r   <= gidx_s;
                    end
                end
                ST_RD: begin
                    // Capture read data already incremented; wraps modulo 2^DW
                    state_r <= ST_WR;
                    le_r    <= 1'b0;
                    daten_r <= 1'b1;
                    dato_r  <= bus.iDato + DAT_ONE;
                end
                ST_WR: begin
                    state_r <= ST_IDLE;
                    le_r    <= 1'b1;
                    daten_r <= 1'b0;
                    dato_r  <= '0;
                    pend_r  <= (pend_r | cap_s) & ~own_s;
                    ack_r   <= own_s;
                end
                ST_CLR: begin
                    if (dir_r == DIR_LAST) begin
                        state_r    <= ST_IDLE;
                        le_r       <= 1'b1;
                        daten_r    <= 1'b0;
                        clr_pend_r <= 1'b0;
                    end else begin
                        dir_r <= dir_r + DIR_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    le_r    <= 1'b1;
                    daten_r <= 1'b0;
                    dato_r  <= '0;
                end
            endcase
        end
    end

    assign bus.oBusy   = pend_r;
    assign bus.oAck    = ack_r;
    assign bus.oDrop   = drop_r;
    assign bus.oErr    = err_r;
    assign bus.oDir    = dir_r;
    assign bus.oLE     = le_r;
    assign bus.oDatoEn = daten_r;
    assign bus.oDato   = dato_r;

endmodule
